lfsr_stream_gen: RTL and testbench
==================================

// Module: lfsr_stream_gen
// PURPOSE
//  Parametrised Fibonacci XNOR LFSR pattern generator with a register-mapped config port,
//  a valid/ready output stream and selectable termination modes (free-run, stop-on-match,
//  stop-on-count). Feeds test/dither pixel streams into the pixel pipeline.
// PARAMETERS
//  WIDTH  16       LFSR, seed, stop and count register width (>=4)
//  TAPS   16'hB400 feedback tap mask, bit i set = state[i] feeds the XNOR (x^16+x^14+x^13+x^11)
// PORTS
//  clk_i          in   1      single clock, all logic on rising edge
//  nreset_i       in   1      reset, synchronous, active-low
//  cfg_wr_i       in   1      config write strobe
//  cfg_addr_i     in   2      0=SEED 1=STOP 2=COUNT 3=MODE
//  cfg_data_i     in   WIDTH  write data (MODE uses bits [1:0])
//  cfg_ack_o      out  1      1-cycle pulse, cycle after an accepted write
//  cfg_rd_data_o  out  WIDTH  combinational read of register at cfg_addr_i (MODE zero-extended)
//  start_i        in   1      start a run (honoured in IDLE only)
//  abort_i        in   1      cancel run, return to IDLE
//  lfsr_data_o    out  WIDTH  current LFSR word
//  lfsr_valid_o   out  1      lfsr_data_o valid
//  lfsr_ready_i   in   1      consumer accepts word when valid&ready
//  busy_o         out  1      high in LOAD/RUN/DONE
//  done_o         out  1      1-cycle pulse on normal termination
//  lockup_o       out  1      sticky lock-up flag (macro-dependent, see CONFIGURATION)
// BEHAVIOUR
//  Reset (nreset_i=0 at clk edge): FSM=IDLE; SEED/STOP/COUNT=0, MODE=0; all outputs 0.
//  Config: write accepted only in IDLE; dropped (no ack, no change) when busy_o=1.
//  MODE: 0 free-run, 1 stop-on-match, 2 stop-on-count, 3 match OR count (first wins).
//  FSM IDLE: start_i=1 & abort_i=0 -> LOAD. abort_i has priority over start_i.
//  FSM LOAD (1 cycle): state<=SEED, acc_cnt<=0 -> RUN. valid low.
//  FSM RUN: lfsr_valid_o=1, lfsr_data_o=state. No accept: state held (stable under stall).
//   On accept: state<={state[WIDTH-2:0], ~^(state & TAPS)}; acc_cnt<=acc_cnt+1 (WIDTH bits, wraps).
//   Termination evaluated on the accepted word: match = (word==STOP) in MODE 1/3;
//   count = (acc_cnt+1==COUNT) in MODE 2/3; COUNT=0 disables count termination.
//   Terminating word is delivered, then RUN -> DONE; valid drops the next cycle.
//  FSM DONE (1 cycle): done_o=1, valid=0 -> IDLE. state retained, lfsr_data_o shows last+1 word.
//  abort_i in LOAD/RUN/DONE: -> IDLE next cycle, valid=0, no done_o pulse; pending word dropped.
//  start_i while busy_o=1 ignored. Latency start_i -> first valid: 2 cycles.
//  Free-run (MODE 0) ends only on abort_i. Seed 0 legal (XNOR lock state is all-ones).
//  Reset mid-run: same as reset; config registers cleared.
// CONFIGURATION
//  Macro LFSR_LOCKUP_RECOVER_EN:
//   defined: in RUN, accepting an all-ones word forces next state to '0 (not all-ones),
//     sets lockup_o; lockup_o clears on LOAD. Termination checks unaffected.
//   undefined: no detection; all-ones repeats forever; lockup_o tied 0.
// TESTING  (WIDTH=16, TAPS=16'hB400, ready=1 unless stated)
//  1 SEED=0x0001 MODE=2 COUNT=4, start -> words 0001,0003,0007,000F; done_o 1 cycle later, valid 0.
//  2 SEED=0x0001 MODE=1 STOP=0x0007 -> 0001,0003,0007 then done_o; MODE=3 COUNT=2 -> stops after 0003.
//  3 MODE=0, ready low 3 cycles after 0003 -> data holds 0003, valid high; resumes 0007 on ready.
//  4 abort_i during RUN after 2 words -> valid 0 next cycle, no done_o, busy_o 0; restart repeats 0001.
//  5 cfg write SEED=0x1234 while busy -> no cfg_ack_o, readback unchanged; in IDLE -> ack, reads 1234.
//  6 SEED=0xFFFF MODE=0: macro on -> FFFF,0000,0001, lockup_o=1; macro off -> FFFF repeated, lockup_o=0.

Source files
------------

// File: rtl/lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// lfsr_stream_gen
//   Fibonacci XNOR LFSR pattern generator with a small register-mapped config
//   port and a valid/ready output stream. A run loads SEED, then emits one
//   LFSR word per accepted transfer until the selected termination condition
//   fires (free-run, stop-on-match, stop-on-count, or match-or-count).
//
//   Optional feature macro: LFSR_LOCKUP_RECOVER_EN
//     defined   : accepting the all-ones word (the XNOR lock state) forces the
//                 next state to all-zeros and sets the sticky lockup_o flag,
//                 which clears when the next run loads its seed.
//     undefined : no lock-up detection, lockup_o is tied low.
// -----------------------------------------------------------------------------
module lfsr_stream_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             clk_i,
    input  logic             nreset_i,
    input  logic             cfg_wr_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [WIDTH-1:0] cfg_data_i,
    output logic             cfg_ack_o,
    output logic [WIDTH-1:0] cfg_rd_data_o,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] lfsr_data_o,
    output logic             lfsr_valid_o,
    input  logic             lfsr_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             lockup_o
);

    // Register map addresses
    localparam logic [1:0] ADDR_SEED  = 2'd0;
    localparam logic [1:0] ADDR_STOP  = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;
    localparam logic [1:0] ADDR_MODE  = 2'd3;

    // Termination modes
    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_MATCH = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;
    localparam logic [1:0] MODE_BOTH  = 2'd3;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    // XNOR of the tapped state bits; all-ones is the stuck state.
    function automatic logic lfsr_feedback(input logic [WIDTH-1:0] cur);
        return ~^(cur & TAPS);
    endfunction

    // One Fibonacci shift: feedback enters at bit 0.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        return {cur[WIDTH-2:0], lfsr_feedback(cur)};
    endfunction

    // True when the word is the XNOR lock-up state.
    function automatic logic is_lock_state(input logic [WIDTH-1:0] cur);
        return (cur == ONES_W);
    endfunction

    // Configuration registers
    logic [WIDTH-1:0] seed_q,  seed_d;
    logic [WIDTH-1:0] stop_q,  stop_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [1:0]       mode_q,  mode_d;
    logic             ack_q,   ack_d;

    // Run state
    logic [1:0]       fsm_q,     fsm_d;
    logic [WIDTH-1:0] state_q,   state_d;
    logic [WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic             lockup_q,  lockup_d;
`endif

    // Decoded conditions
    logic             cfg_accept_s;
    logic             accept_s;
    logic             match_s;
    logic             count_hit_s;
    logic             term_s;
    logic [WIDTH-1:0] acc_cnt_inc_s;

    // Condition decode for config accept, stream transfer and termination
    always_comb begin
        cfg_accept_s  = cfg_wr_i && (fsm_q == ST_IDLE);
        accept_s      = valid_q && lfsr_ready_i;
        acc_cnt_inc_s = acc_cnt_q + ONE_W;
        if ((mode_q == MODE_MATCH) || (mode_q == MODE_BOTH)) begin
            match_s = (state_q == stop_q);
        end else begin
            match_s = 1'b0;
        end
        if (((mode_q == MODE_COUNT) || (mode_q == MODE_BOTH)) && (count_q != ZERO_W)) begin
            count_hit_s = (acc_cnt_inc_s == count_q);
        end else begin
            count_hit_s = 1'b0;
        end
        if (mode_q == MODE_FREE) begin
            term_s = 1'b0;
        end else begin
            term_s = match_s || count_hit_s;
        end
    end

    // Config register writes, accepted only while idle
    always_comb begin
        seed_d  = seed_q;
        stop_d  = stop_q;
        count_d = count_q;
        mode_d  = mode_q;
        ack_d   = cfg_accept_s;
        if (cfg_accept_s) begin
            case (cfg_addr_i)
                ADDR_SEED:  seed_d  = cfg_data_i;
                ADDR_STOP:  stop_d  = cfg_data_i;
                ADDR_COUNT: count_d = cfg_data_i;
                ADDR_MODE:  mode_d  = cfg_data_i[1:0];
                default:    seed_d  = seed_q;
            endcase
        end else begin
            ack_d = 1'b0;
        end
    end

    // Run FSM, LFSR advance, accepted-word counter and output flags
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
`ifdef LFSR_LOCKUP_RECOVER_EN
        lockup_d  = lockup_q;
`endif
        case (fsm_q)
            ST_IDLE: begin
                // abort_i outranks start_i
                if (start_i && !abort_i) begin
                    fsm_d = ST_LOAD;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    fsm_d = ST_IDLE;
                end else begin
                    fsm_d     = ST_RUN;
                    state_d   = seed_q;
                    acc_cnt_d = ZERO_W;
`ifdef LFSR_LOCKUP_RECOVER_EN
                    lockup_d  = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                // An abort drops the word on offer, even if it is being accepted
                if (abort_i) begin
                    fsm_d = ST_IDLE;
                end else if (accept_s) begin
                    acc_cnt_d = acc_cnt_inc_s;
`ifdef LFSR_LOCKUP_RECOVER_EN
                    if (is_lock_state(state_q)) begin
                        state_d  = ZERO_W;
                        lockup_d = 1'b1;
                    end else begin
                        state_d  = lfsr_step(state_q);
                    end
`else
                    state_d = lfsr_step(state_q);
`endif
                    if (term_s) begin
                        fsm_d = ST_DONE;
                    end else begin
                        fsm_d = ST_RUN;
                    end
                end else begin
                    // Stalled: hold the word steady
                    fsm_d = ST_RUN;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        // Output flags follow the next state so they are registered outputs
        valid_d = (fsm_d == ST_RUN);
        busy_d  = (fsm_d != ST_IDLE);
        done_d  = (fsm_d == ST_DONE);
    end

    // Synchronous active-low reset for all state
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            seed_q    <= ZERO_W;
            stop_q    <= ZERO_W;
            count_q   <= ZERO_W;
            mode_q    <= 2'd0;
            ack_q     <= 1'b0;
            fsm_q     <= ST_IDLE;
            state_q   <= ZERO_W;
            acc_cnt_q <= ZERO_W;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
            lockup_q  <= 1'b0;
`endif
        end else begin
            seed_q    <= seed_d;
            stop_q    <= stop_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            ack_q     <= ack_d;
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef LFSR_LOCKUP_RECOVER_EN
            lockup_q  <= lockup_d;
`endif
        end
    end

    // Combinational register readback, MODE zero-extended
    always_comb begin
        case (cfg_addr_i)
            ADDR_SEED:  cfg_rd_data_o = seed_q;
            ADDR_STOP:  cfg_rd_data_o = stop_q;
            ADDR_COUNT: cfg_rd_data_o = count_q;
            ADDR_MODE:  cfg_rd_data_o = {{(WIDTH-2){1'b0}}, mode_q};
            default:    cfg_rd_data_o = ZERO_W;
        endcase
    end

    assign cfg_ack_o    = ack_q;
    assign lfsr_data_o  = state_q;
    assign lfsr_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign lockup_o = lockup_q;
`else
    assign lockup_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream_gen
//   Directed bench for lfsr_stream_gen (WIDTH=16, TAPS=16'hB400). Expected
//   words are hand-computed: from seed 0001 the XNOR sequence is
//   0001, 0003, 0007, 000F, 001F ...; from FFFF it is stuck at FFFF unless
//   LFSR_LOCKUP_RECOVER_EN is defined, in which case FFFF, 0000, 0001.
// -----------------------------------------------------------------------------
module tb_lfsr_stream_gen;

    logic        clk;
    logic        nreset;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_ack;
    logic [15:0] cfg_rd_data;
    logic        start;
    logic        abort_s;
    logic [15:0] lfsr_data;
    logic        lfsr_valid;
    logic        lfsr_ready;
    logic        busy;
    logic        done;
    logic        lockup;

    int checks = 0;
    int passed = 0;

    lfsr_stream_gen #(.WIDTH(16), .TAPS(16'hB400)) dut (
        .clk_i        (clk),
        .nreset_i     (nreset),
        .cfg_wr_i     (cfg_wr),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .cfg_ack_o    (cfg_ack),
        .cfg_rd_data_o(cfg_rd_data),
        .start_i      (start),
        .abort_i      (abort_s),
        .lfsr_data_o  (lfsr_data),
        .lfsr_valid_o (lfsr_valid),
        .lfsr_ready_i (lfsr_ready),
        .busy_o       (busy),
        .done_o       (done),
        .lockup_o     (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single config write; reports whether ack appeared the following cycle
    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data, output logic ack);
        cfg_wr   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_wr   = 1'b0;
        ack      = cfg_ack;
    endtask

    // Pulse start; afterwards the design sits in LOAD
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Pulse abort for one cycle
    task automatic pulse_abort();
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp0;
        exp0 = 16'h0000;
        nreset = 1'b0;
        tick();
        tick();
        checks++;
        if ({lfsr_valid, busy, done, cfg_ack, lockup} !== 5'b00000) $display("FAIL reset_flags: got %b want 00000", {lfsr_valid, busy, done, cfg_ack, lockup});
        else passed++;
        checks++;
        if (lfsr_data !== exp0) $display("FAIL reset_data: got %h want %h", lfsr_data, exp0);
        else passed++;
        nreset = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            cfg_addr = a[1:0];
            #1;
            checks++;
            if (cfg_rd_data !== exp0) $display("FAIL reset_reg%0d: got %h want %h", a, cfg_rd_data, exp0);
            else passed++;
        end
    endtask

    task automatic test_count_stop();
        logic        ack;
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h0001; exp_w[1] = 16'h0003; exp_w[2] = 16'h0007; exp_w[3] = 16'h000F;
        cfg_write(2'd0, 16'h0001, ack);
        checks++;
        if (ack !== 1'b1) $display("FAIL cnt_cfg_ack: got %b want 1", ack);
        else passed++;
        cfg_write(2'd2, 16'h0004, ack);
        cfg_write(2'd3, 16'h0002, ack);
        lfsr_ready = 1'b1;
        pulse_start();
        checks++;
        if ({lfsr_valid, busy} !== 2'b01) $display("FAIL cnt_load: valid/busy got %b want 01", {lfsr_valid, busy});
        else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lfsr_valid !== 1'b1 || lfsr_data !== exp_w[i]) $display("FAIL cnt_word%0d: got v=%b %h want v=1 %h", i, lfsr_valid, lfsr_data, exp_w[i]);
            else passed++;
            tick();
        end
        checks++;
        if ({done, lfsr_valid, busy} !== 3'b101 || lfsr_data !== 16'h001F) $display("FAIL cnt_done: got d/v/b=%b data=%h want 101 001F", {done, lfsr_valid, busy}, lfsr_data);
        else passed++;
        tick();
        checks++;
        if ({done, busy} !== 2'b00) $display("FAIL cnt_idle: got done/busy=%b want 00", {done, busy});
        else passed++;
    endtask

    task automatic test_match_stop();
        logic        ack;
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h0001; exp_w[1] = 16'h0003; exp_w[2] = 16'h0007;
        cfg_write(2'd1, 16'h0007, ack);
        cfg_write(2'd3, 16'h0001, ack);
        pulse_start();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lfsr_valid !== 1'b1 || lfsr_data !== exp_w[i]) $display("FAIL match_word%0d: got v=%b %h want v=1 %h", i, lfsr_valid, lfsr_data, exp_w[i]);
            else passed++;
            tick();
        end
        checks++;
        if ({done, lfsr_valid} !== 2'b10) $display("FAIL match_done: got done/valid=%b want 10", {done, lfsr_valid});
        else passed++;
        tick();
        // MODE 3: count of 2 wins before the match at 0007
        cfg_write(2'd2, 16'h0002, ack);
        cfg_write(2'd3, 16'h0003, ack);
        cfg_addr = 2'd3;
        #1;
        checks++;
        if (cfg_rd_data !== 16'h0003) $display("FAIL mode_readback: got %h want 0003", cfg_rd_data);
        else passed++;
        pulse_start();
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (lfsr_valid !== 1'b1 || lfsr_data !== exp_w[i]) $display("FAIL both_word%0d: got v=%b %h want v=1 %h", i, lfsr_valid, lfsr_data, exp_w[i]);
            else passed++;
            tick();
        end
        checks++;
        if ({done, lfsr_valid} !== 2'b10 || lfsr_data !== 16'h0007) $display("FAIL both_done: got done/valid=%b data=%h want 10 0007", {done, lfsr_valid}, lfsr_data);
        else passed++;
        tick();
    endtask

    task automatic test_stall();
        logic ack;
        cfg_write(2'd3, 16'h0000, ack);
        lfsr_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        lfsr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (lfsr_valid !== 1'b1 || lfsr_data !== 16'h0003) $display("FAIL stall_hold%0d: got v=%b %h want v=1 0003", i, lfsr_valid, lfsr_data);
            else passed++;
        end
        lfsr_ready = 1'b1;
        tick();
        checks++;
        if (lfsr_valid !== 1'b1 || lfsr_data !== 16'h0007) $display("FAIL stall_resume: got v=%b %h want v=1 0007", lfsr_valid, lfsr_data);
        else passed++;
        pulse_abort();
    endtask

    task automatic test_abort();
        // abort outranks start in IDLE
        start   = 1'b1;
        abort_s = 1'b1;
        tick();
        start   = 1'b0;
        abort_s = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL abort_prio: busy got %b want 0", busy);
        else passed++;
        pulse_start();
        tick();
        tick();
        tick();
        // start while busy is ignored
        pulse_start();
        checks++;
        if (lfsr_valid !== 1'b1 || lfsr_data !== 16'h000F) $display("FAIL start_busy: got v=%b %h want v=1 000F", lfsr_valid, lfsr_data);
        else passed++;
        pulse_abort();
        checks++;
        if ({lfsr_valid, done, busy} !== 3'b000) $display("FAIL abort_run: got v/d/b=%b want 000", {lfsr_valid, done, busy});
        else passed++;
        tick();
        checks++;
        if (done !== 1'b0) $display("FAIL abort_nodone: got %b want 0", done);
        else passed++;
        pulse_start();
        tick();
        checks++;
        if (lfsr_valid !== 1'b1 || lfsr_data !== 16'h0001) $display("FAIL abort_restart: got v=%b %h want v=1 0001", lfsr_valid, lfsr_data);
        else passed++;
    endtask

    task automatic test_cfg_busy();
        logic ack;
        // run from test_abort is still active here
        cfg_write(2'd0, 16'h1234, ack);
        checks++;
        if (ack !== 1'b0) $display("FAIL busy_ack: got %b want 0", ack);
        else passed++;
        cfg_addr = 2'd0;
        #1;
        checks++;
        if (cfg_rd_data !== 16'h0001) $display("FAIL busy_readback: got %h want 0001", cfg_rd_data);
        else passed++;
        pulse_abort();
        cfg_write(2'd0, 16'h1234, ack);
        checks++;
        if (ack !== 1'b1) $display("FAIL idle_ack: got %b want 1", ack);
        else passed++;
        tick();
        checks++;
        if (cfg_ack !== 1'b0) $display("FAIL ack_pulse: got %b want 0", cfg_ack);
        else passed++;
        cfg_addr = 2'd0;
        #1;
        checks++;
        if (cfg_rd_data !== 16'h1234) $display("FAIL idle_readback: got %h want 1234", cfg_rd_data);
        else passed++;
    endtask

    task automatic test_lockup();
        logic        ack;
        logic [15:0] exp_w [3];
        logic        exp_lk;
`ifdef LFSR_LOCKUP_RECOVER_EN
        exp_w[0] = 16'hFFFF; exp_w[1] = 16'h0000; exp_w[2] = 16'h0001;
        exp_lk   = 1'b1;
`else
        exp_w[0] = 16'hFFFF; exp_w[1] = 16'hFFFF; exp_w[2] = 16'hFFFF;
        exp_lk   = 1'b0;
`endif
        cfg_write(2'd0, 16'hFFFF, ack);
        cfg_write(2'd3, 16'h0000, ack);
        lfsr_ready = 1'b1;
        pulse_start();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (lfsr_valid !== 1'b1 || lfsr_data !== exp_w[i]) $display("FAIL lock_word%0d: got v=%b %h want v=1 %h", i, lfsr_valid, lfsr_data, exp_w[i]);
            else passed++;
            tick();
        end
        checks++;
        if (lockup !== exp_lk) $display("FAIL lockup_flag: got %b want %b", lockup, exp_lk);
        else passed++;
        pulse_abort();
        checks++;
        if (lockup !== exp_lk) $display("FAIL lockup_sticky: got %b want %b", lockup, exp_lk);
        else passed++;
        // the flag clears when the next run loads
        cfg_write(2'd0, 16'h0001, ack);
        pulse_start();
        tick();
        checks++;
        if (lockup !== 1'b0 || lfsr_data !== 16'h0001) $display("FAIL lockup_clear: got lk=%b %h want 0 0001", lockup, lfsr_data);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        checks++;
        if ({lfsr_valid, busy, done} !== 3'b000 || lfsr_data !== 16'h0000) $display("FAIL midrun_reset: got v/b/d=%b %h want 000 0000", {lfsr_valid, busy, done}, lfsr_data);
        else passed++;
        cfg_addr = 2'd0;
        #1;
        checks++;
        if (cfg_rd_data !== 16'h0000) $display("FAIL midrun_seed: got %h want 0000", cfg_rd_data);
        else passed++;
    endtask

    initial begin
        nreset     = 1'b0;
        cfg_wr     = 1'b0;
        cfg_addr   = 2'd0;
        cfg_data   = 16'h0000;
        start      = 1'b0;
        abort_s    = 1'b0;
        lfsr_ready = 1'b1;
        test_reset();
        test_count_stop();
        test_match_stop();
        test_stall();
        test_abort();
        test_cfg_busy();
        test_lockup();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
